// File: rtl/div_arbiter.sv
// Round-robin arbiter that shares one iterative divider between two requesters,
// short-circuits divide-by-zero and bounds each operation with a timeout.
// Optional signed support is compiled in when DIV_SIGNED_EN is defined.
module div_arbiter #(
  parameter int TIMEOUT_CYCLES = 200,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  input  logic [63:0] req_dv,
  input  logic [63:0] req_dr,
`ifdef DIV_SIGNED_EN
  input  logic [1:0]  req_signed,
`endif
  output logic [1:0]  req_ack,
  output logic [1:0]  resp_done,
  output logic [31:0] resp_result,
  output logic        resp_err,
  output logic        busy,
  output logic [31:0] div_dv,
  output logic [31:0] div_dr,
  output logic        div_init,
  input  logic        div_ready,
  input  logic [31:0] div_result
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE,
    RESP
  } state_t;

  state_t            state_q;
  logic              ptr_q;
  logic              gnt_q;
  logic [31:0]       dv_q;
  logic [31:0]       dr_q;
  logic              neg_q;
  logic [31:0]       result_q;
  logic              err_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [1:0]        req_ack_q;
  logic [1:0]        resp_done_q;
  logic [31:0]       resp_result_q;
  logic              resp_err_q;
  logic              busy_q;
  logic [31:0]       div_dv_q;
  logic [31:0]       div_dr_q;
  logic              div_init_q;

  logic [31:0]       dv_slice [2];
  logic [31:0]       dr_slice [2];

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_unpack
    assign dv_slice[gi] = req_dv[32*gi +: 32];
    assign dr_slice[gi] = req_dr[32*gi +: 32];
  end

  // On a tie the requester that was not granted last wins.
  logic        gnt_d;
  logic [31:0] sel_dv;
  logic [31:0] sel_dr;
  logic [31:0] dv_mag_d;
  logic [31:0] dr_mag_d;
  logic        neg_d;
  logic        ovf_d;

  always_comb begin
    gnt_d = (req_valid == 2'b11) ? ~ptr_q : req_valid[1];
    sel_dv = dv_slice[gnt_d];
    sel_dr = dr_slice[gnt_d];
`ifdef DIV_SIGNED_EN
    dv_mag_d = (req_signed[gnt_d] && sel_dv[31]) ? (~sel_dv + 32'd1) : sel_dv;
    dr_mag_d = (req_signed[gnt_d] && sel_dr[31]) ? (~sel_dr + 32'd1) : sel_dr;
    neg_d    = req_signed[gnt_d] && (sel_dv[31] ^ sel_dr[31]);
    // Most-negative / -1 overflows the magnitude path; answer it directly.
    ovf_d    = req_signed[gnt_d] && (sel_dv == 32'h8000_0000) && (sel_dr == 32'hFFFF_FFFF);
`else
    dv_mag_d = sel_dv;
    dr_mag_d = sel_dr;
    neg_d    = 1'b0;
    ovf_d    = 1'b0;
`endif
  end

  logic [CNT_W-1:0] cnt_inc;
  logic             timeout_hit;
  assign cnt_inc     = cnt_q + 1'b1;
  assign timeout_hit = (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      ptr_q         <= 1'b1;
      gnt_q         <= 1'b0;
      dv_q          <= '0;
      dr_q          <= '0;
      neg_q         <= 1'b0;
      result_q      <= '0;
      err_q         <= 1'b0;
      cnt_q         <= '0;
      req_ack_q     <= '0;
      resp_done_q   <= '0;
      resp_result_q <= '0;
      resp_err_q    <= 1'b0;
      busy_q        <= 1'b0;
      div_dv_q      <= '0;
      div_dr_q      <= '0;
      div_init_q    <= 1'b0;
    end else begin
      req_ack_q     <= '0;
      resp_done_q   <= '0;
      resp_result_q <= '0;
      resp_err_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|req_valid) begin
            gnt_q     <= gnt_d;
            req_ack_q <= 2'b01 << gnt_d;
            busy_q    <= 1'b1;
            dv_q      <= dv_mag_d;
            dr_q      <= dr_mag_d;
            neg_q     <= neg_d;
            if (sel_dr == 32'd0) begin
              result_q <= 32'hFFFF_FFFF;
              err_q    <= 1'b0;
              state_q  <= RESP;
            end else if (ovf_d) begin
              result_q <= 32'h8000_0000;
              err_q    <= 1'b0;
              state_q  <= RESP;
            end else begin
              state_q  <= ISSUE;
            end
          end
        end
        ISSUE: begin
          div_dv_q   <= dv_q;
          div_dr_q   <= dr_q;
          div_init_q <= 1'b1;
          cnt_q      <= '0;
          state_q    <= WAIT_ACK;
        end
        WAIT_ACK: begin
          cnt_q <= cnt_inc;
          if (timeout_hit) begin
            div_init_q <= 1'b0;
            result_q   <= '0;
            err_q      <= 1'b1;
            state_q    <= RESP;
          end else if (!div_ready) begin
            div_init_q <= 1'b0;
            state_q    <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          cnt_q <= cnt_inc;
          if (timeout_hit) begin
            result_q <= '0;
            err_q    <= 1'b1;
            state_q  <= RESP;
          end else if (div_ready) begin
            result_q <= neg_q ? (~div_result + 32'd1) : div_result;
            err_q    <= 1'b0;
            state_q  <= RESP;
          end
        end
        RESP: begin
          resp_done_q   <= 2'b01 << gnt_q;
          resp_result_q <= result_q;
          resp_err_q    <= err_q;
          busy_q        <= 1'b0;
          ptr_q         <= gnt_q;
          state_q       <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ack     = req_ack_q;
  assign resp_done   = resp_done_q;
  assign resp_result = resp_result_q;
  assign resp_err    = resp_err_q;
  assign busy        = busy_q;
  assign div_dv      = div_dv_q;
  assign div_dr      = div_dr_q;
  assign div_init    = div_init_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Scoreboard bench for div_arbiter with a behavioural multi-cycle divider that
// can be switched into a hung mode to exercise the timeout path.
module tb_div_arbiter;

  localparam int TMO = 20;
  localparam int LAT = 8;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid;
  logic [63:0] req_dv;
  logic [63:0] req_dr;
`ifdef DIV_SIGNED_EN
  logic [1:0]  req_signed;
`endif
  logic [1:0]  req_ack;
  logic [1:0]  resp_done;
  logic [31:0] resp_result;
  logic        resp_err;
  logic        busy;
  logic [31:0] div_dv;
  logic [31:0] div_dr;
  logic        div_init;
  logic        div_ready;
  logic [31:0] div_result;

  div_arbiter #(.TIMEOUT_CYCLES(TMO), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_dv(req_dv), .req_dr(req_dr),
`ifdef DIV_SIGNED_EN
    .req_signed(req_signed),
`endif
    .req_ack(req_ack), .resp_done(resp_done), .resp_result(resp_result),
    .resp_err(resp_err), .busy(busy), .div_dv(div_dv), .div_dr(div_dr),
    .div_init(div_init), .div_ready(div_ready), .div_result(div_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural divider: accepts on init by dropping ready, answers LAT cycles later.
  logic dm_hung;
  logic dm_busy;
  int   dm_cnt;
  always @(posedge clk) begin
    if (reset) begin
      div_ready  <= 1'b1;
      div_result <= '0;
      dm_busy    <= 1'b0;
      dm_cnt     <= 0;
    end else if (!dm_hung) begin
      if (!dm_busy && div_init) begin
        dm_busy    <= 1'b1;
        div_ready  <= 1'b0;
        dm_cnt     <= LAT;
        div_result <= (div_dr != 0) ? div_dv / div_dr : 32'hFFFF_FFFF;
      end else if (dm_busy) begin
        if (dm_cnt == 0) begin
          div_ready <= 1'b1;
          dm_busy   <= 1'b0;
        end else begin
          dm_cnt <= dm_cnt - 1;
        end
      end
    end
  end

  typedef struct {
    int          r;
    logic [31:0] res;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   ack_cyc = 0;
  int   done_cyc = 0;
  int   init_rises = 0;
  logic init_prev = 1'b0;
  logic rearm0 = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (div_init && !init_prev) init_rises++;
    init_prev = div_init;
    for (int i = 0; i < 2; i++) begin
      if (req_ack[i]) begin
        req_valid[i] = 1'b0;
        ack_cyc = cyc;
        $display("cycle %0d: ack req%0d", cyc, i);
      end
    end
    if (resp_done != 2'b00) begin
      done_cyc = cyc;
      $display("cycle %0d: done=%b result=0x%08h err=%0b", cyc, resp_done, resp_result, resp_err);
      if (sb.size() == 0) begin
        check("unexpected_done", {62'd0, resp_done}, 64'd0);
      end else begin
        e = sb.pop_front();
        check("done_who", {62'd0, resp_done}, 64'd1 << e.r);
        check("result", {32'd0, resp_result}, {32'd0, e.res});
        check("err", {63'd0, resp_err}, {63'd0, e.err});
      end
      if (rearm0 && resp_done[0]) begin
        rearm0 = 1'b0;
        req_valid[0] = 1'b1;
        req_dv[31:0] = 32'd81;
        req_dr[31:0] = 32'd9;
        sb.push_back('{0, 32'd9, 1'b0});
      end
    end
  endtask

  task automatic drive(input int r, input logic [31:0] dv, input logic [31:0] dr,
                       input logic sgn, input logic expect_it, input logic [31:0] res,
                       input logic err);
    req_valid[r] = 1'b1;
    req_dv[32*r +: 32] = dv;
    req_dr[32*r +: 32] = dr;
`ifdef DIV_SIGNED_EN
    req_signed[r] = sgn;
`else
    if (sgn) $display("note: signed request issued to unsigned build");
`endif
    if (expect_it) sb.push_back('{r, res, err});
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((sb.size() != 0 || busy || req_valid != 2'b00) && n < budget) begin
      step();
      n++;
    end
    check(tag, {63'd0, n < budget}, 64'd1);
  endtask

  initial begin
    int vcyc;
    reset = 1'b1;
    req_valid = '0;
    req_dv = '0;
    req_dr = '0;
`ifdef DIV_SIGNED_EN
    req_signed = '0;
`endif
    dm_hung = 1'b0;
    step();
    step();
    check("rst_ack", {62'd0, req_ack}, 64'd0);
    check("rst_done", {62'd0, resp_done}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_init", {63'd0, div_init}, 64'd0);
    check("rst_dvdr", {div_dv, div_dr}, 64'd0);

    // Tie from reset: req0 first, then req1; req0 re-armed at its done loses the next tie.
    drive(0, 32'd50, 32'd5, 1'b0, 1'b1, 32'd10, 1'b0);
    drive(1, 32'd9, 32'd3, 1'b0, 1'b1, 32'd3, 1'b0);
    rearm0 = 1'b1;
    reset = 1'b0;
    step();
    check("tie_first_ack", {62'd0, req_ack}, 64'd1);
    wait_idle("tie_budget", 200);

    // Plain unsigned divide with ack latency and a single init sequence.
    init_rises = 0;
    drive(0, 32'd100, 32'd7, 1'b0, 1'b1, 32'd14, 1'b0);
    vcyc = cyc;
    step();
    check("ack_latency", ack_cyc - vcyc, 64'd1);
    check("busy_held", {63'd0, busy}, 64'd1);
    wait_idle("div_budget", 100);
    check("init_once", init_rises, 64'd1);

    // Divide-by-zero bypasses the divider.
    init_rises = 0;
    drive(1, 32'd123, 32'd0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
    wait_idle("dbz_budget", 20);
    check("dbz_no_init", init_rises, 64'd0);
    check("dbz_latency", done_cyc - ack_cyc, 64'd1);

    // Hung divider: ready stays high, timeout fires after TMO wait cycles.
    dm_hung = 1'b1;
    drive(0, 32'd1000, 32'd10, 1'b0, 1'b1, 32'd0, 1'b1);
    wait_idle("tmo_budget", 100);
    check("tmo_latency", done_cyc - ack_cyc, TMO + 2);
    check("tmo_idle_busy", {63'd0, busy}, 64'd0);
    check("tmo_init_low", {63'd0, div_init}, 64'd0);
    dm_hung = 1'b0;

    // Reset while the divider is working: the operation vanishes.
    drive(1, 32'd5000, 32'd7, 1'b0, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 10 && req_valid[1]; i++) step();
    step();
    step();
    step();
    reset = 1'b1;
    step();
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_init", {63'd0, div_init}, 64'd0);
    check("mid_rst_outs", {28'd0, req_ack, resp_done, div_dv}, 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) step();
    drive(0, 32'hFFFF_FFFF, 32'h10, 1'b0, 1'b1, 32'h0FFF_FFFF, 1'b0);
    wait_idle("post_rst_budget", 100);

`ifdef DIV_SIGNED_EN
    drive(0, 32'hFFFF_FF9C, 32'd7, 1'b1, 1'b1, 32'hFFFF_FFF2, 1'b0);
    wait_idle("sgn_budget", 100);
    init_rises = 0;
    drive(1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h8000_0000, 1'b0);
    wait_idle("ovf_budget", 20);
    check("ovf_no_init", init_rises, 64'd0);
`endif

    for (int i = 0; i < 5; i++) step();
    check("sb_empty", sb.size(), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_arbiter.md
Name: div_arbiter

Overview:
- Shares one `divisor` datapath between two requesters, e.g. the CPU execute stage and a peripheral/DMA master.
- Grants requesters round-robin and sequences the divider's init/ready handshake.
- Short-circuits divide-by-zero without using the divider.
- Bounds every divider operation with a timeout, so a hung divider cannot stall the requesters.

Parameters:
- TIMEOUT_CYCLES, default 200: clk cycles allowed from div_init assertion to div_ready rising. The divider needs about 70; on expiry the arbiter returns an error.
- CNT_W, default 8: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- req_valid  in  2  bit i: requester i has an operation pending; held high until req_ack[i].
- req_dv  in  64  dividends, packed; requester i uses [32i+31:32i]. Stable while req_valid[i]=1.
- req_dr  in  64  divisors, packed the same way.
- req_ack  out  2  one-cycle pulse: operands of requester i latched.
- resp_done  out  2  one-cycle pulse: result for requester i valid this cycle.
- resp_result  out  32  quotient; valid only when resp_done≠0.
- resp_err  out  1  timeout flag, qualified by resp_done.
- busy  out  1  high from grant through RESP.
- div_dv  out  32  to divider DV_in.
- div_dr  out  32  to divider DR_in.
- div_init  out  1  to divider init.
- div_ready  in  1  from divider ready.
- div_result  in  32  from divider result.

Behaviour:
- Reset: all outputs 0; state IDLE; round-robin pointer set so requester 0 wins the first tie; timeout counter 0.
- Reset mid-operation: the in-flight operation is dropped, with no resp_done pulse. The divider shares the same reset.
- States: IDLE, ISSUE, WAIT_ACK, WAIT_DONE, RESP.
- IDLE:
  - If any req_valid bit is set, grant one requester. A lone requester wins; on a tie, the requester not granted last wins.
  - Latch its dv/dr into internal regs, pulse req_ack[g] that cycle, set busy.
  - If the latched dr = 0: set result to 0xFFFFFFFF, err = 0, go to RESP (divider is not used).
  - Otherwise go to ISSUE.
- ISSUE: drive div_dv/div_dr from the latched regs, assert div_init, clear the timeout counter, go to WAIT_ACK.
  - div_dv/div_dr hold their values until the next grant.
- WAIT_ACK:
  - Keep div_init=1 until div_ready is sampled 0 (divider accepted the operation).
  - Then drop div_init and go to WAIT_DONE.
- WAIT_DONE: when div_ready is sampled 1, capture div_result, set err = 0, go to RESP.
- Timeout counter:
  - Increments every cycle in WAIT_ACK and WAIT_DONE.
  - On reaching TIMEOUT_CYCLES: drop div_init, set result = 0, err = 1, go to RESP.
  - Timeout takes priority over a simultaneous div_ready event.
- RESP:
  - Pulse resp_done[g] with resp_result/resp_err valid, update the pointer to g, clear busy, go to IDLE.
  - No req_ack is issued in RESP, so back-to-back grants are at least 1 cycle apart.
- Latency:
  - req_ack follows req_valid by 1 cycle when idle.
  - Divide-by-zero: resp_done comes 1 cycle after req_ack.
  - Normal operation: 3 + (divider latency) cycles after req_ack.
- A requester may raise req_valid again in the cycle after its resp_done.
- req_valid dropped before req_ack is legal; the request is not served.
- div_ready is sampled only in WAIT_ACK/WAIT_DONE, so its value before the divider's first operation is don't-care.

Optional Feature:
- DIV_SIGNED_EN defined:
  - Adds input req_signed[1:0], latched with the operands.
  - Signed requests: negative operands are two's-complement negated before issue, and the quotient is negated when the operand signs differ.
  - 0x80000000 / 0xFFFFFFFF returns 0x80000000 via the short-circuit path; dr = 0 still returns 0xFFFFFFFF.
- DIV_SIGNED_EN undefined: port absent; all operations unsigned.

Test Plan:
- Requester 0, dv=100, dr=7 → req_ack[0] pulse, one div_init sequence, resp_done[0] with resp_result=14, resp_err=0.
- Both req_valid high from reset, dv=50/dr=5 (req 0) and dv=9/dr=3 (req 1) → req 0 served first with 10, then req 1 with 3; with both re-asserted immediately, req 1 wins the next tie.
- Requester 1, dv=123, dr=0 → div_init never asserted; resp_done[1] one cycle after req_ack with 0xFFFFFFFF.
- Divider model holding div_ready=1 forever, TIMEOUT_CYCLES=20 → resp_done with resp_err=1 and resp_result=0 after 20 wait cycles; arbiter back in IDLE.
- reset asserted during WAIT_DONE → no resp_done, all outputs 0 next cycle; a new request 0xFFFFFFFF/0x10 completes with 0x0FFFFFFF.
- DIV_SIGNED_EN, signed: -100/7 → 0xFFFFFFF2 (-14); 0x80000000/-1 → 0x80000000 without div_init.
